// File: rtl/input_conditioner_pkg.sv
// rtl/input_conditioner_pkg.sv - shared defaults and per-channel state encodings
package input_conditioner_pkg;

  localparam int DEF_N                 = 3;
  localparam int DEF_SYNC_STAGES       = 2;
  localparam int SIM_DEBOUNCE_CYCLES   = 4;
  // Roughly 10 ms at a 50 MHz board clock.
  localparam int BOARD_DEBOUNCE_CYCLES = 500000;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } chan_state_e;

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// rtl/input_conditioner_debounce_channel.sv - one channel: synchroniser, stability counter, edge pulses
module input_conditioner_debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = SIM_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sync;
  chan_state_e            state;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], raw};
  assign sync   = sync_q[SYNC_STAGES-1];

  // Any return to the accepted level drops straight back to STABLE and clears the count.
  always_comb begin
    state   = (sync == clean_q) ? ST_STABLE : ST_PENDING;
    cnt_d   = '0;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state)
      ST_PENDING: begin
        if (cnt_q == CNT_MAX) begin
          clean_d = sync;
          rise_d  = sync;
          fall_d  = ~sync;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign clean = clean_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - N independent synchronised, debounced inputs with rise/fall pulses
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int N               = DEF_N,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = SIM_DEBOUNCE_CYCLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] raw,
  output logic [N-1:0] clean,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  for (genvar g = 0; g < N; g++) begin : g_chan
    input_conditioner_debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw[g]),
      .clean(clean[g]),
      .rise (rise[g]),
      .fall (fall[g])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - directed self-checking bench for input_conditioner
module tb_input_conditioner;

  logic       clk;
  logic       rst;
  logic [2:0] raw;
  logic [2:0] clean;
  logic [2:0] rise;
  logic [2:0] fall;

  int n_checks;
  int n_errors;

  input_conditioner #(
    .N              (3),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .raw  (raw),
    .clean(clean),
    .rise (rise),
    .fall (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle; inputs set after this are sampled on the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [2:0] c, input logic [2:0] r,
                            input logic [2:0] f);
    check_eq({tag, ".clean"}, 32'(clean), 32'(c));
    check_eq({tag, ".rise"},  32'(rise),  32'(r));
    check_eq({tag, ".fall"},  32'(fall),  32'(f));
  endtask

  int rise_cnt;
  int fall_cnt;
  int rise_edge;
  int clean1_seen;
  logic [8:0] bounce;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    raw = 3'b111;

    // Reset held with raw high: everything stays 0.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_outs("reset", 3'b000, 3'b000, 3'b000);
    end
    rst = 1'b0;
    for (int e = 0; e < 5; e++) tick();
    check_outs("rel_e4", 3'b000, 3'b000, 3'b000);
    tick();
    check_outs("rel_e5", 3'b111, 3'b111, 3'b000);
    tick();
    check_outs("rel_e6", 3'b111, 3'b000, 3'b000);

    // All three drop together.
    raw = 3'b000;
    for (int e = 0; e < 5; e++) tick();
    check_outs("fall_e4", 3'b111, 3'b000, 3'b000);
    tick();
    check_outs("fall_e5", 3'b000, 3'b000, 3'b111);
    tick();
    check_outs("fall_e6", 3'b000, 3'b000, 3'b000);

    // Channel 0 steady rise; others untouched.
    raw = 3'b001;
    for (int e = 0; e < 5; e++) tick();
    check_outs("ch0_e4", 3'b000, 3'b000, 3'b000);
    tick();
    check_outs("ch0_e5", 3'b001, 3'b001, 3'b000);
    tick();
    check_outs("ch0_e6", 3'b001, 3'b000, 3'b000);

    // Channel 1: 3-cycle pulse rejected.
    rise_cnt = 0;
    clean1_seen = 0;
    raw = 3'b011;
    for (int e = 0; e < 10; e++) begin
      if (e == 3) raw = 3'b001;
      tick();
      if (rise[1]) rise_cnt++;
      if (clean[1]) clean1_seen++;
    end
    check_eq("ch1_short_rise", 32'(rise_cnt), 32'd0);
    check_eq("ch1_short_clean", 32'(clean1_seen), 32'd0);

    // Channel 1: exactly 4 cycles accepted with one pulse, at edge 5.
    rise_cnt = 0;
    rise_edge = -1;
    raw = 3'b011;
    for (int e = 0; e < 8; e++) begin
      if (e == 4) raw = 3'b001;
      tick();
      if (rise[1]) begin
        rise_cnt++;
        rise_edge = e;
      end
    end
    check_eq("ch1_min_rise_cnt", 32'(rise_cnt), 32'd1);
    check_eq("ch1_min_rise_edge", 32'(rise_edge), 32'd5);
    check_eq("ch1_min_clean", 32'(clean), 32'b011);
    fall_cnt = 0;
    for (int e = 0; e < 6; e++) begin
      tick();
      if (fall[1]) fall_cnt++;
    end
    check_eq("ch1_min_fall_cnt", 32'(fall_cnt), 32'd1);
    check_eq("ch1_min_clean_back", 32'(clean), 32'b001);

    // Channel 2 bounce 1,0,1,1,0,1,1,1,1 then steady 1: one rise at edge 10.
    bounce = 9'b111101101;
    rise_cnt = 0;
    fall_cnt = 0;
    rise_edge = -1;
    for (int e = 0; e < 16; e++) begin
      raw[2] = (e < 9) ? bounce[e] : 1'b1;
      tick();
      if (rise[2]) begin
        rise_cnt++;
        rise_edge = e;
      end
      if (fall[2]) fall_cnt++;
    end
    check_eq("ch2_bounce_rise_cnt", 32'(rise_cnt), 32'd1);
    check_eq("ch2_bounce_rise_edge", 32'(rise_edge), 32'd10);
    check_eq("ch2_bounce_fall_cnt", 32'(fall_cnt), 32'd0);
    check_eq("ch2_bounce_clean", 32'(clean), 32'b101);

    // Reset mid-count on channel 0.
    raw = 3'b100;
    for (int e = 0; e < 8; e++) tick();
    check_outs("pre_rst", 3'b100, 3'b000, 3'b000);
    raw = 3'b101;
    for (int e = 0; e < 3; e++) tick();
    rst = 1'b1;
    tick();
    check_outs("mid_rst", 3'b000, 3'b000, 3'b000);
    rst = 1'b0;
    rise_cnt = 0;
    for (int e = 0; e < 5; e++) begin
      tick();
      if (rise != 3'b000) rise_cnt++;
    end
    check_eq("post_rst_early_rise", 32'(rise_cnt), 32'd0);
    check_eq("post_rst_e4_clean", 32'(clean), 32'b000);
    tick();
    check_outs("post_rst_e5", 3'b101, 3'b101, 3'b000);
    tick();
    check_outs("post_rst_e6", 3'b101, 3'b000, 3'b000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
